// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial add/subtract datapath.
//   state_t          : controller states (IDLE, ADD, DONE)
//   MODE_ADD/MODE_SUB: values of the mode input
//   count_width()    : width of the step counter for a given step count
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A counter always needs at least one bit, even for a single step.
  function automatic int count_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple adder used once per serial step.
//   a_dig, b_dig : operand digits
//   cin          : carry into bit 0
//   sum          : digit sum
//   cout         : carry out of the digit's top bit
//   c_msb_in     : carry into the digit's top bit (for signed overflow)
module serial_digit_adder
  import serial_arith_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  always_comb begin
    logic c;
    c        = cin;
    c_msb_in = cin;
    sum      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      sum[i] = a_dig[i] ^ b_dig[i] ^ c;
      c      = (a_dig[i] & b_dig[i]) | (c & (a_dig[i] ^ b_dig[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor with valid/ready handshake on both sides.
//   clk, rst             : clock, asynchronous active-low reset
//   en, mode, a, b       : request (mode 0 = a+b, 1 = a-b), taken when in_ready
//   in_ready             : a request can be accepted this cycle
//   out                  : result, built LSB-first from the top end
//   carry_out, overflow  : unsigned carry (1 = no borrow on sub), signed overflow
//   out_valid, out_ready : result handshake
//
// state | meaning
// IDLE  | waiting for a request
// ADD   | one DIGIT-wide slice added per cycle, STEPS cycles total
// DONE  | result and flags held until the consumer takes them
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = count_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    count;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;
  logic             accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = en && in_ready;

  serial_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_dig    (a_reg[DIGIT-1:0]),
    .b_dig    (b_reg[DIGIT-1:0]),
    .cin      (carry),
    .sum      (dig_sum),
    .cout     (dig_cout),
    .c_msb_in (dig_cmsb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      count     <= '0;
      out       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      // Covers both a fresh start from IDLE and back-to-back retire+accept.
      // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
      a_reg     <= a;
      b_reg     <= (mode == MODE_SUB) ? ~b : b;
      carry     <= mode;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      state     <= ADD;
    end else begin
      case (state)
        IDLE: ;
        ADD: begin
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          // Concatenate then shift so the DIGIT==WIDTH case needs no special slice.
          out   <= WIDTH'({dig_sum, out} >> DIGIT);
          carry <= dig_cout;
          count <= count + 1'b1;
          if (count == LAST) begin
            carry_out <= dig_cout;
            overflow  <= dig_cmsb ^ dig_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;

  logic        en8, mode8, in_ready8, carry8, ovf8, valid8, ordy8;
  logic [7:0]  a8, b8, out8;
  logic        en16, mode16, in_ready16, carry16, ovf16, valid16, ordy16;
  logic [15:0] a16, b16, out16;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .a(a8), .b(b8),
    .in_ready(in_ready8), .out(out8), .carry_out(carry8), .overflow(ovf8),
    .out_valid(valid8), .out_ready(ordy8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .mode(mode16), .a(a16), .b(b16),
    .in_ready(in_ready16), .out(out16), .carry_out(carry16), .overflow(ovf16),
    .out_valid(valid16), .out_ready(ordy16)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int w, input longint a, input longint b, input bit m,
                                output longint r, output bit c, output bit v);
    longint md, sa, sb, sres;
    md   = longint'(1) << w;
    sa   = (a >= md / 2) ? a - md : a;
    sb   = (b >= md / 2) ? b - md : b;
    sres = m ? sa - sb : sa + sb;
    r    = m ? (a - b + md) % md : (a + b) % md;
    c    = m ? (a >= b) : (a + b >= md);
    v    = (sres >= md / 2) || (sres < -(md / 2));
  endfunction

  function automatic bit f_valid(input int s);
    return (s == 0) ? valid8 : valid16;
  endfunction
  function automatic bit f_in_ready(input int s);
    return (s == 0) ? in_ready8 : in_ready16;
  endfunction
  function automatic longint f_out(input int s);
    return (s == 0) ? longint'(out8) : longint'(out16);
  endfunction
  function automatic bit f_carry(input int s);
    return (s == 0) ? carry8 : carry16;
  endfunction
  function automatic bit f_ovf(input int s);
    return (s == 0) ? ovf8 : ovf16;
  endfunction

  task automatic drive(input int s, input bit e, input bit m, input longint a, input longint b);
    if (s == 0) begin
      en8 = e; mode8 = m; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      en16 = e; mode16 = m; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  task automatic set_ordy(input int s, input bit v);
    if (s == 0) ordy8 = v;
    else ordy16 = v;
  endtask

  // Waits for in_ready, then presents the request for exactly one edge.
  task automatic start(input int s, input longint a, input longint b, input bit m);
    int k = 0;
    while (!f_in_ready(s) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("ready_before_accept", f_in_ready(s), 1);
    drive(s, 1'b1, m, a, b);
    @(posedge clk); #1;
    drive(s, 1'b0, ~m, $urandom, $urandom);
    chk("in_ready_during_add", f_in_ready(s), 0);
  endtask

  // Called #1 after the accept edge: waits for the result, checks it, holds, retires.
  task automatic finish(input int s, input longint a, input longint b, input bit m,
                        input int hold, input bit noise, input bit retire);
    int w = (s == 0) ? 8 : 16;
    int steps = (s == 0) ? 8 : 4;
    int k = 0;
    longint r;
    bit c, v;
    model(w, a, b, m, r, c, v);
    // Requests offered while busy must be ignored.
    drive(s, noise, $urandom_range(1), $urandom, $urandom);
    while (!f_valid(s) && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("latency_edges", k + 1, steps + 1);
    chk("result", f_out(s), r);
    chk("carry_out", f_carry(s), c);
    chk("overflow", f_ovf(s), v);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", f_valid(s), 1);
      chk("hold_result", f_out(s), r);
      chk("hold_flags", {f_carry(s), f_ovf(s)}, {c, v});
      chk("hold_in_ready", f_in_ready(s), 0);
    end
    drive(s, 1'b0, 1'b0, $urandom, $urandom);
    if (retire) begin
      set_ordy(s, 1'b1);
      #1;
      chk("in_ready_on_retire", f_in_ready(s), 1);
      @(posedge clk); #1;
      set_ordy(s, 1'b0);
      chk("valid_after_retire", f_valid(s), 0);
      chk("result_kept", f_out(s), r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    longint ra, rb;
    bit     rm;
    int     s;

    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    ordy8 = 0; ordy16 = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("reset_out", out8, 0);
    chk("reset_valid", valid8, 0);
    chk("reset_flags", {carry8, ovf8}, 0);
    chk("reset_in_ready", in_ready8, 1);
    chk("reset_out16", out16, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases, 8-bit single-bit-serial.
    start(0, 100, 27, 0);   finish(0, 100, 27, 0, 0, 0, 1);
    start(0, 200, 100, 0);  finish(0, 200, 100, 0, 1, 1, 1);
    start(0, 127, 1, 0);    finish(0, 127, 1, 0, 0, 1, 1);
    start(0, 5, 7, 1);      finish(0, 5, 7, 1, 0, 0, 1);
    start(0, 'h80, 1, 1);   finish(0, 'h80, 1, 1, 0, 1, 1);

    // Stall five cycles in DONE, then back-to-back retire + accept of 3+4.
    start(0, 90, 9, 1);
    finish(0, 90, 9, 1, 5, 1, 0);
    drive(0, 1'b1, 1'b0, 3, 4);
    set_ordy(0, 1'b1);
    #1;
    chk("b2b_in_ready", in_ready8, 1);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
    drive(0, 1'b0, 1'b1, 'hAA, 'h55);
    chk("b2b_valid_drop", valid8, 0);
    finish(0, 3, 4, 0, 0, 1, 1);

    // 16-bit, four bits per step.
    start(1, 'hFFFF, 1, 0); finish(1, 'hFFFF, 1, 0, 0, 0, 1);
    start(1, 'h7FFF, 'hFFFF, 1); finish(1, 'h7FFF, 'hFFFF, 1, 2, 1, 1);

    // Reset during the 4th ADD cycle aborts with nothing flagged valid.
    start(0, 'h7F, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_out", out8, 0);
    chk("abort_valid", valid8, 0);
    chk("abort_flags", {carry8, ovf8}, 0);
    chk("abort_in_ready", in_ready8, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    start(0, 3, 4, 0);      finish(0, 3, 4, 0, 0, 0, 1);

    // Randomised operations on both widths.
    for (int i = 0; i < 40; i++) begin
      s  = $urandom_range(1);
      ra = (s == 0) ? longint'($urandom_range(255)) : longint'($urandom_range(65535));
      rb = (s == 0) ? longint'($urandom_range(255)) : longint'($urandom_range(65535));
      rm = $urandom_range(1);
      start(s, ra, rb, rm);
      finish(s, ra, rb, rm, $urandom_range(3), $urandom_range(1), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
